// File: rtl/score_digit_scanner_pkg.sv
// ---------------------------------------------------------------------------
// score_disp_pkg
// Shared types and constants for the bowling score digit scanner.
//   state_t  : converter FSM states (IDLE, CONV, LOAD)
//   BCD_W    : bits per BCD digit
//   ADD3_TH  : double-dabble correction threshold (nibble >= 5 gets +3)
//   clog2    : width helper for counters and indices (never returns 0)
// ---------------------------------------------------------------------------
package score_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] ADD3_TH = 4'd5;

    // Minimum 1 so that a single-digit or single-step counter still has a bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_digit_scanner_if.sv
// ---------------------------------------------------------------------------
// score_digit_scanner_if
// Bundles the score load request and the multiplexed display outputs.
//   score        : binary value to display
//   score_valid  : single-cycle load request (dropped while busy)
//   busy         : conversion in progress
//   digit_bcd    : BCD of the currently selected digit
//   digit_an_n   : active-low one-hot digit select (all ones = blanked)
// Handshake: a request is accepted on a clock edge where score_valid=1 and
// busy=0; requests seen while busy=1 are discarded, never queued.
// ---------------------------------------------------------------------------
interface score_digit_scanner_if #(
    parameter int SCORE_W    = 9,
    parameter int NUM_DIGITS = 3
);
    logic [SCORE_W-1:0]    score;
    logic                  score_valid;
    logic                  busy;
    logic [3:0]            digit_bcd;
    logic [NUM_DIGITS-1:0] digit_an_n;

    modport master (
        output score, score_valid,
        input  busy, digit_bcd, digit_an_n
    );

    modport slave (
        input  score, score_valid,
        output busy, digit_bcd, digit_an_n
    );
endinterface

// File: rtl/score_digit_scanner_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst   : clock, synchronous active-high reset
//   i_start    : begin conversion of i_bin (honoured only in IDLE)
//   i_bin      : binary input, captured on the start edge
//   o_busy     : high in CONV and LOAD
//   o_done     : high for the single LOAD cycle; o_bcd is final then
//   o_bcd      : BCD digits, digit 0 in the low nibble
//   o_state    : FSM state for observation
// ---------------------------------------------------------------------------
module bin2bcd_seq
    import score_disp_pkg::*;
#(
    parameter int SCORE_W    = 9,
    parameter int NUM_DIGITS = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_start,
    input  logic [SCORE_W-1:0]            i_bin,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [NUM_DIGITS*BCD_W-1:0]   o_bcd,
    output state_t                        o_state
);
    localparam int REG_W = SCORE_W + NUM_DIGITS * BCD_W;
    localparam int CNT_W = clog2(SCORE_W);

    state_t             r_state;
    logic [REG_W-1:0]   r_shift;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [REG_W-1:0]   w_adj;
    logic [REG_W-1:0]   w_next;

    // Add-3 correction on every BCD nibble, then shift the whole {bcd, bin}
    // vector left. Carries out of the top nibble are lost, so oversize
    // values wrap modulo 10^NUM_DIGITS.
    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_shift[SCORE_W + d*BCD_W +: BCD_W] >= ADD3_TH) begin
                w_adj[SCORE_W + d*BCD_W +: BCD_W] =
                    r_shift[SCORE_W + d*BCD_W +: BCD_W] + 4'd3;
            end
        end
        w_next = {w_adj[REG_W-2:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_shift <= REG_W'(i_bin);
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_shift <= w_next;
                    if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                        r_done  <= 1'b1;
                        r_state <= LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LOAD: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_bcd   = r_shift[REG_W-1:SCORE_W];
    assign o_state = r_state;
endmodule

// File: rtl/score_digit_scanner.sv
// ---------------------------------------------------------------------------
// score_digit_scanner
// Converts a binary score to BCD, holds the digits and time-multiplexes
// them onto one shared BCD bus with active-low digit selects.
//   clk, rst     : clock, synchronous active-high reset
//   bus (slave)  : score/score_valid in; busy, digit_bcd, digit_an_n out
//   o_dbg_state  : converter FSM state for observation
// Outputs depend only on the registered scan index and shown digits.
// ---------------------------------------------------------------------------
module score_digit_scanner
    import score_disp_pkg::*;
#(
    parameter int SCORE_W    = 9,
    parameter int NUM_DIGITS = 3,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_LZ   = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    score_digit_scanner_if.slave   bus,
    output state_t                 o_dbg_state
);
    localparam int PRE_W = clog2(SCAN_DIV);
    localparam int IDX_W = clog2(NUM_DIGITS);

    logic                          w_busy;
    logic                          w_done;
    logic                          w_start;
    logic [NUM_DIGITS*BCD_W-1:0]   w_bcd;
    logic [BCD_W-1:0]              r_shown [NUM_DIGITS];
    logic [PRE_W-1:0]              r_pre;
    logic [IDX_W-1:0]              r_idx;
    logic [NUM_DIGITS-1:0]         w_blank;
    logic                          w_zero_above;
    logic [BCD_W-1:0]              w_sel_bcd;
    logic                          w_sel_blank;

    assign w_start = bus.score_valid && !w_busy;

    bin2bcd_seq #(
        .SCORE_W    (SCORE_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_bin   (bus.score),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_bcd   (w_bcd),
        .o_state (o_dbg_state)
    );

    // Displayed digits change only when a conversion completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_shown[d] <= '0;
            end
        end else if (w_done) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                r_shown[d] <= w_bcd[d*BCD_W +: BCD_W];
            end
        end
    end

    // Free-running scan, independent of conversions.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_W'(SCAN_DIV - 1)) begin
            r_pre <= '0;
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end else begin
            r_pre <= r_pre + 1'b1;
        end
    end

    // Walk down from the top digit: a digit is blank while it and every
    // digit above it are zero. Digit 0 is never blanked.
    always_comb begin
        w_blank      = '0;
        w_zero_above = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above && (r_shown[k] == '0);
            w_blank[k]   = (BLANK_LZ != 0) && w_zero_above;
        end
    end

    always_comb begin
        w_sel_bcd   = '0;
        w_sel_blank = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (r_idx == IDX_W'(d)) begin
                w_sel_bcd   = r_shown[d];
                w_sel_blank = w_blank[d];
            end
        end
    end

    // digit_bcd keeps the real (zero) digit value when blanked so the
    // decoder never sees a non-BCD code.
    assign bus.busy       = w_busy;
    assign bus.digit_bcd  = w_sel_bcd;
    assign bus.digit_an_n = w_sel_blank ? '1
                                        : ~(NUM_DIGITS'(1) << r_idx);
endmodule

// File: tb/tb_score_digit_scanner.sv
module tb_score_digit_scanner;
  import score_disp_pkg::*;

  localparam int SCORE_W    = 9;
  localparam int NUM_DIGITS = 3;
  localparam int SCAN_DIV   = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  score_digit_scanner_if #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) bus_a ();
  score_digit_scanner_if #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) bus_b ();
  state_t dbg_a;
  state_t dbg_b;

  score_digit_scanner #(
    .SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
  ) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a.slave), .o_dbg_state(dbg_a)
  );

  score_digit_scanner #(
    .SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)
  ) u_dut_nb (
    .clk(clk), .rst(rst), .bus(bus_b.slave), .o_dbg_state(dbg_b)
  );

  int checks = 0;
  int errors = 0;

  // reference scan position: edges since the last reset edge
  int scan_cnt = 0;
  always @(posedge clk) begin
    if (rst) scan_cnt <= 0;
    else     scan_cnt <= scan_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive(input logic [SCORE_W-1:0] s, input logic v);
    bus_a.score = s;
    bus_a.score_valid = v;
    bus_b.score = s;
    bus_b.score_valid = v;
  endtask

  task automatic pulse(input logic [SCORE_W-1:0] s);
    @(negedge clk);
    drive(s, 1'b1);
    @(negedge clk);
    drive(s, 1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (bus_a.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  // one full scan, each cycle checked against the expected digit for the
  // reference scan position
  task automatic check_scan(input string tag, input bit use_b,
                            input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] b2,
                            input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    int k;
    logic [3:0] eb;
    logic [2:0] ea;
    for (int i = 0; i < NUM_DIGITS * SCAN_DIV; i++) begin
      @(negedge clk);
      k = (scan_cnt / SCAN_DIV) % NUM_DIGITS;
      case (k)
        0:       begin eb = b0; ea = a0; end
        1:       begin eb = b1; ea = a1; end
        default: begin eb = b2; ea = a2; end
      endcase
      if (use_b) begin
        chk({tag, "_bcd"}, 32'(bus_b.digit_bcd), 32'(eb));
        chk({tag, "_an"}, 32'(bus_b.digit_an_n), 32'(ea));
      end else begin
        chk({tag, "_bcd"}, 32'(bus_a.digit_bcd), 32'(eb));
        chk({tag, "_an"}, 32'(bus_a.digit_an_n), 32'(ea));
      end
    end
  endtask

  initial begin
    int n;
    drive('0, 1'b0);

    // reset, with a load request that must lose to reset
    rst = 1'b1;
    repeat (2) @(negedge clk);
    drive(9'd300, 1'b1);
    @(negedge clk);
    drive('0, 1'b0);
    chk("rst_busy_held", 32'(bus_a.busy), 32'd0);
    rst = 1'b0;
    chk("rst_busy", 32'(bus_a.busy), 32'd0);
    chk("rst_state", 32'(dbg_a), 32'(IDLE));
    chk("rst_bcd", 32'(bus_a.digit_bcd), 32'd0);
    chk("rst_an", 32'(bus_a.digit_an_n), 32'b110);
    check_scan("rst_scan", 1'b0, 4'd0, 4'd0, 4'd0, 3'b110, 3'b111, 3'b111);

    // 300
    pulse(9'd300);
    wait_idle(n);
    chk("s300_busy_len", 32'(n), 32'd10);
    check_scan("s300", 1'b0, 4'd0, 4'd0, 4'd3, 3'b110, 3'b101, 3'b011);

    // 57, with and without leading-zero blanking
    pulse(9'd57);
    wait_idle(n);
    chk("s57_busy_len", 32'(n), 32'd10);
    check_scan("s57", 1'b0, 4'd7, 4'd5, 4'd0, 3'b110, 3'b101, 3'b111);
    check_scan("s57_nb", 1'b1, 4'd7, 4'd5, 4'd0, 3'b110, 3'b101, 3'b011);

    // 0
    pulse(9'd0);
    wait_idle(n);
    chk("s0_busy_len", 32'(n), 32'd10);
    check_scan("s0", 1'b0, 4'd0, 4'd0, 4'd0, 3'b110, 3'b111, 3'b111);

    // 123, then 9 requested three cycles later while busy
    @(negedge clk);
    drive(9'd123, 1'b1);
    @(negedge clk);
    drive(9'd123, 1'b0);
    repeat (2) @(negedge clk);
    chk("s123_busy_mid", 32'(bus_a.busy), 32'd1);
    drive(9'd9, 1'b1);
    @(negedge clk);
    drive(9'd9, 1'b0);
    wait_idle(n);
    chk("s123_busy_rest", 32'(n), 32'd7);
    repeat (3) @(negedge clk);
    chk("s9_not_queued", 32'(bus_a.busy), 32'd0);
    check_scan("s123", 1'b0, 4'd3, 4'd2, 4'd1, 3'b110, 3'b101, 3'b011);

    // reset during the 5th conversion cycle of 511
    pulse(9'd511);
    repeat (4) @(negedge clk);
    chk("s511_state_conv", 32'(dbg_a), 32'(CONV));
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(bus_a.busy), 32'd0);
    chk("abort_state", 32'(dbg_a), 32'(IDLE));
    chk("abort_bcd", 32'(bus_a.digit_bcd), 32'd0);
    chk("abort_an", 32'(bus_a.digit_an_n), 32'b110);
    rst = 1'b0;
    check_scan("abort_scan", 1'b0, 4'd0, 4'd0, 4'd0, 3'b110, 3'b111, 3'b111);

    pulse(9'd511);
    wait_idle(n);
    chk("s511_busy_len", 32'(n), 32'd10);
    check_scan("s511", 1'b0, 4'd1, 4'd1, 4'd5, 3'b110, 3'b101, 3'b011);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
